// File: rtl/proc_gen_pkg.sv
// Shared opcodes, T-step encoding and decode helper for the proc_gen datapath.
package proc_gen_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  // Moves finish in T1; everything else runs through the A/G accumulator.
  function automatic logic is_move(input logic [2:0] op);
    return (op == OP_MV) || (op == OP_MVI);
  endfunction

endpackage

// File: rtl/proc_gen_alu.sv
// Combinational 8-op ALU for proc_gen. With PROC_FLAGS_EN defined it also
// produces a carry/borrow/shift-out bit.
module proc_gen_alu
  import proc_gen_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [N-1:0] o_result
`ifdef PROC_FLAGS_EN
  ,output logic        o_carry
`endif
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] w_sh;
  assign w_sh = i_b[SW-1:0];

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SHL:  o_result = i_a << w_sh;
      default: o_result = i_b;
    endcase
  end

`ifdef PROC_FLAGS_EN
  // One extra MSB catches carry-out, borrow (A<B) and the last bit shifted out.
  logic [N:0] w_add, w_sub, w_shl;
  assign w_add = {1'b0, i_a} + {1'b0, i_b};
  assign w_sub = {1'b0, i_a} - {1'b0, i_b};
  assign w_shl = {1'b0, i_a} << w_sh;

  always_comb begin
    o_carry = 1'b0;
    case (i_op)
      OP_ADD:  o_carry = w_add[N];
      OP_SUB:  o_carry = w_sub[N];
      OP_SHL:  o_carry = w_shl[N];
      default: o_carry = 1'b0;
    endcase
  end
`endif

endmodule

// File: rtl/proc_gen.sv
// Multi-cycle bus processor: 2^RSEL x N register file, A/G accumulator, shared
// bus mux and T0..T3 sequencer. Define PROC_FLAGS_EN to add Z/C flag outputs.
module proc_gen
  import proc_gen_pkg::*;
#(
  parameter int N    = 8,
  parameter int RSEL = 2
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic [N-1:0]    Data,
  input  logic            w,
  input  logic [2:0]      F,
  input  logic [RSEL-1:0] Rx,
  input  logic [RSEL-1:0] Ry,
  output logic            Done,
  output logic [N-1:0]    BusWires,
  output logic            Busy
`ifdef PROC_FLAGS_EN
  ,output logic           Z,
  output logic            C
`endif
);

  localparam int NREG = 2 ** RSEL;

  logic [1:0]                r_tstep;
  logic [2:0]                r_f;
  logic [RSEL-1:0]           r_rx, r_ry;
  logic [NREG-1:0][N-1:0]    r_regs;
  logic [N-1:0]              r_a, r_g;
  logic [N-1:0]              w_bus, w_alu;
  logic                      w_move;

  assign w_move = is_move(r_f);

  // One source per T-step; idle steps drive zero.
  always_comb begin
    w_bus = '0;
    case (r_tstep)
      T1: begin
        if (r_f == OP_MV)       w_bus = r_regs[r_ry];
        else if (r_f == OP_MVI) w_bus = Data;
        else                    w_bus = r_regs[r_rx];
      end
      T2:      w_bus = r_regs[r_ry];
      T3:      w_bus = r_g;
      default: w_bus = '0;
    endcase
  end

  assign BusWires = w_bus;
  assign Busy     = (r_tstep != T0);
  assign Done     = (r_tstep == T3) || ((r_tstep == T1) && w_move);

`ifdef PROC_FLAGS_EN
  logic w_carry;
  proc_gen_alu #(.N(N)) u_alu (
    .i_a      (r_a),
    .i_b      (w_bus),
    .i_op     (r_f),
    .o_result (w_alu),
    .o_carry  (w_carry)
  );
`else
  proc_gen_alu #(.N(N)) u_alu (
    .i_a      (r_a),
    .i_b      (w_bus),
    .i_op     (r_f),
    .o_result (w_alu)
  );
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_tstep <= T0;
      r_f     <= '0;
      r_rx    <= '0;
      r_ry    <= '0;
      r_regs  <= '0;
      r_a     <= '0;
      r_g     <= '0;
    end else begin
      case (r_tstep)
        T0: if (w) begin
          r_f     <= F;
          r_rx    <= Rx;
          r_ry    <= Ry;
          r_tstep <= T1;
        end
        T1: begin
          if (w_move) begin
            r_regs[r_rx] <= w_bus;
            r_tstep      <= T0;
          end else begin
            r_a     <= w_bus;
            r_tstep <= T2;
          end
        end
        T2: begin
          r_g     <= w_alu;
          r_tstep <= T3;
        end
        default: begin
          r_regs[r_rx] <= w_bus;
          r_tstep      <= T0;
        end
      endcase
    end
  end

`ifdef PROC_FLAGS_EN
  // Flags move only with G, so moves leave them untouched.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Z <= 1'b0;
      C <= 1'b0;
    end else if (r_tstep == T2) begin
      Z <= (w_alu == '0);
      C <= w_carry;
    end
  end
`endif

endmodule

// File: tb/tb_proc_gen.sv
// Directed, table-driven bench for proc_gen (N=8/RSEL=2 plus an N=16/RSEL=3 instance).
module tb_proc_gen;
  import proc_gen_pkg::*;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [7:0] Data;
  logic       w;
  logic [2:0] F;
  logic [1:0] Rx, Ry;
  logic       Done, Busy;
  logic [7:0] BusWires;
`ifdef PROC_FLAGS_EN
  logic       Z, C;
`endif

  logic [15:0] b_Data;
  logic        b_w;
  logic [2:0]  b_F;
  logic [2:0]  b_Rx, b_Ry;
  logic        b_Done, b_Busy;
  logic [15:0] b_Bus;
`ifdef PROC_FLAGS_EN
  logic        b_Z, b_C;
`endif

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  proc_gen #(.N(8), .RSEL(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .Data(Data), .w(w), .F(F), .Rx(Rx), .Ry(Ry),
    .Done(Done), .BusWires(BusWires), .Busy(Busy)
`ifdef PROC_FLAGS_EN
    , .Z(Z), .C(C)
`endif
  );

  proc_gen #(.N(16), .RSEL(3)) dut16 (
    .Clock(Clock), .Resetn(Resetn), .Data(b_Data), .w(b_w), .F(b_F), .Rx(b_Rx), .Ry(b_Ry),
    .Done(b_Done), .BusWires(b_Bus), .Busy(b_Busy)
`ifdef PROC_FLAGS_EN
    , .Z(b_Z), .C(b_C)
`endif
  );

  typedef struct {
    logic [2:0] f;
    logic [1:0] rx, ry;
    logic [7:0] d;
    logic [7:0] exp_t1;
    logic [7:0] exp_res;
    logic       chkf, exp_z, exp_c;
  } vec_t;

  vec_t vecs[27];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Issues one instruction from T0; returns cycles including the T0 cycle.
  task automatic exec(input logic [2:0] f, input logic [1:0] rx, input logic [1:0] ry,
                      input logic [7:0] d, output int lat, output logic [7:0] t1bus,
                      output logic t1busy);
    F = f; Rx = rx; Ry = ry; Data = d; w = 1'b1;
    @(posedge Clock); #1;
    w = 1'b0;
    t1bus = BusWires; t1busy = Busy; lat = 2;
    while (!Done && lat < 10) begin
      @(posedge Clock); #1;
      lat++;
    end
    @(posedge Clock); #1;
  endtask

  task automatic rd(input logic [1:0] r, output logic [7:0] v);
    int l; logic b;
    exec(OP_MV, r, r, 8'h00, l, v, b);
  endtask

  task automatic exec16(input logic [2:0] f, input logic [2:0] rx, input logic [2:0] ry,
                        input logic [15:0] d, output int lat, output logic [15:0] t1bus);
    b_F = f; b_Rx = rx; b_Ry = ry; b_Data = d; b_w = 1'b1;
    @(posedge Clock); #1;
    b_w = 1'b0;
    t1bus = b_Bus; lat = 2;
    while (!b_Done && lat < 10) begin
      @(posedge Clock); #1;
      lat++;
    end
    @(posedge Clock); #1;
  endtask

  initial begin
    int lat;
    logic [7:0] t1, v;
    logic bz;
    logic [15:0] t16;

    //          f       rx ry  d      t1     res    chkf z c
    vecs[0]  = '{OP_MVI, 0, 0, 8'h5A, 8'h5A, 8'h5A, 0, 0, 0};
    vecs[1]  = '{OP_MV,  1, 0, 8'h00, 8'h5A, 8'h5A, 0, 0, 0};
    vecs[2]  = '{OP_MVI, 2, 0, 8'hF0, 8'hF0, 8'hF0, 0, 0, 0};
    vecs[3]  = '{OP_MVI, 3, 0, 8'h20, 8'h20, 8'h20, 0, 0, 0};
    vecs[4]  = '{OP_ADD, 2, 3, 8'h00, 8'hF0, 8'h10, 1, 0, 1};
    vecs[5]  = '{OP_MVI, 1, 0, 8'h05, 8'h05, 8'h05, 0, 0, 0};
    vecs[6]  = '{OP_SUB, 1, 1, 8'h00, 8'h05, 8'h00, 1, 1, 0};
    vecs[7]  = '{OP_MVI, 1, 0, 8'h3C, 8'h3C, 8'h3C, 0, 0, 0};
    vecs[8]  = '{OP_MVI, 3, 0, 8'h0F, 8'h0F, 8'h0F, 0, 0, 0};
    vecs[9]  = '{OP_XOR, 1, 3, 8'h00, 8'h3C, 8'h33, 1, 0, 0};
    vecs[10] = '{OP_AND, 1, 3, 8'h00, 8'h33, 8'h03, 1, 0, 0};
    vecs[11] = '{OP_OR,  1, 3, 8'h00, 8'h03, 8'h0F, 1, 0, 0};
    vecs[12] = '{OP_MVI, 0, 0, 8'h81, 8'h81, 8'h81, 0, 0, 0};
    vecs[13] = '{OP_MVI, 2, 0, 8'h03, 8'h03, 8'h03, 0, 0, 0};
    vecs[14] = '{OP_SHL, 0, 2, 8'h00, 8'h81, 8'h08, 1, 0, 0};
    vecs[15] = '{OP_MVI, 2, 0, 8'h08, 8'h08, 8'h08, 0, 0, 0};
    vecs[16] = '{OP_SHL, 0, 2, 8'h00, 8'h08, 8'h08, 1, 0, 0};
    vecs[17] = '{OP_MVI, 0, 0, 8'hA0, 8'hA0, 8'hA0, 0, 0, 0};
    vecs[18] = '{OP_MVI, 2, 0, 8'h01, 8'h01, 8'h01, 0, 0, 0};
    vecs[19] = '{OP_SHL, 0, 2, 8'h00, 8'hA0, 8'h40, 1, 0, 1};
    vecs[20] = '{OP_MVI, 1, 0, 8'h02, 8'h02, 8'h02, 0, 0, 0};
    vecs[21] = '{OP_SUB, 1, 3, 8'h00, 8'h02, 8'hF3, 1, 0, 1};
    vecs[22] = '{OP_MVI, 3, 0, 8'h77, 8'h77, 8'h77, 1, 0, 1};
    vecs[23] = '{OP_ADD, 2, 2, 8'h00, 8'h01, 8'h02, 1, 0, 0};
    vecs[24] = '{OP_XOR, 3, 3, 8'h00, 8'h77, 8'h00, 1, 1, 0};
    vecs[25] = '{OP_AND, 0, 1, 8'h00, 8'h40, 8'h40, 1, 0, 0};
    vecs[26] = '{OP_ADD, 1, 1, 8'h00, 8'hF3, 8'hE6, 1, 0, 1};

    Resetn = 1'b0; w = 1'b0; F = '0; Rx = '0; Ry = '0; Data = '0;
    b_w = 1'b0; b_F = '0; b_Rx = '0; b_Ry = '0; b_Data = '0;

    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      chk($sformatf("rst%0d_done", i), Done, 0);
      chk($sformatf("rst%0d_busy", i), Busy, 0);
      chk($sformatf("rst%0d_bus", i), BusWires, 0);
    end
`ifdef PROC_FLAGS_EN
    chk("rst_z", Z, 0);
    chk("rst_c", C, 0);
`endif
    Resetn = 1'b1;
    @(posedge Clock); #1;
    chk("idle_busy", Busy, 0);

    for (int i = 0; i < 27; i++) begin
      exec(vecs[i].f, vecs[i].rx, vecs[i].ry, vecs[i].d, lat, t1, bz);
      chk($sformatf("v%0d_lat", i), lat, (vecs[i].f == OP_MV || vecs[i].f == OP_MVI) ? 2 : 4);
      chk($sformatf("v%0d_t1bus", i), t1, vecs[i].exp_t1);
      chk($sformatf("v%0d_t1busy", i), bz, 1);
`ifdef PROC_FLAGS_EN
      if (vecs[i].chkf) begin
        chk($sformatf("v%0d_z", i), Z, vecs[i].exp_z);
        chk($sformatf("v%0d_c", i), C, vecs[i].exp_c);
      end
`endif
      rd(vecs[i].rx, v);
      chk($sformatf("v%0d_res", i), v, vecs[i].exp_res);
    end

    // w held high with changing F/Rx/Data after T0 must not disturb the add
    exec(OP_MVI, 2, 0, 8'hF0, lat, t1, bz);
    exec(OP_MVI, 3, 0, 8'h20, lat, t1, bz);
    F = OP_ADD; Rx = 2; Ry = 3; w = 1'b1;
    @(posedge Clock); #1;
    F = OP_MVI; Rx = 0; Data = 8'hFF;
    chk("ign_t1_done", Done, 0);
    @(posedge Clock); #1;
    chk("ign_t2_done", Done, 0);
    chk("ign_t2_bus", BusWires, 8'h20);
    w = 1'b0;
    @(posedge Clock); #1;
    chk("ign_t3_done", Done, 1);
    chk("ign_t3_bus", BusWires, 8'h10);
    @(posedge Clock); #1;
    chk("ign_t0_busy", Busy, 0);
    rd(2, v); chk("ign_r2", v, 8'h10);
    rd(0, v); chk("ign_r0", v, 8'h40);

    // Reset during T2 of an add
    F = OP_ADD; Rx = 0; Ry = 1; w = 1'b1;
    @(posedge Clock); #1;
    w = 1'b0;
    @(posedge Clock); #1;
    chk("abort_in_t2_busy", Busy, 1);
    Resetn = 1'b0;
    #1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_bus", BusWires, 0);
    @(posedge Clock); #1;
    Resetn = 1'b1;
    @(posedge Clock); #1;
`ifdef PROC_FLAGS_EN
    chk("abort_z", Z, 0);
    chk("abort_c", C, 0);
`endif
    for (int r = 0; r < 4; r++) begin
      rd(r[1:0], v);
      chk($sformatf("abort_r%0d", r), v, 0);
    end
    exec(OP_MVI, 1, 0, 8'h11, lat, t1, bz);
    chk("post_mvi_lat", lat, 2);
    exec(OP_ADD, 1, 1, 8'h00, lat, t1, bz);
    chk("post_add_lat", lat, 4);
    rd(1, v); chk("post_r1", v, 8'h22);

    // Wider configuration
    exec16(OP_MVI, 7, 0, 16'hBEEF, lat, t16);
    chk("w16_mvi_t1", t16, 16'hBEEF);
    exec16(OP_ADD, 7, 7, 16'h0000, lat, t16);
    chk("w16_add_lat", lat, 4);
`ifdef PROC_FLAGS_EN
    chk("w16_c", b_C, 1);
    chk("w16_z", b_Z, 0);
`endif
    exec16(OP_MV, 7, 7, 16'h0000, lat, t16);
    chk("w16_r7", t16, 16'h7DDE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
